rising_edge_detector: RTL and testbench
=======================================

Name: rising_edge_detector

Overview:
Multi-channel synchronising edge detector. Each bit of an asynchronous input bus passes through a synchroniser. The block then emits a one-cycle pulse on a selected edge type, keeps a per-channel sticky flag, and counts detected edges in a saturating counter. It sits between raw external/asynchronous status lines and the clocked control logic.

Parameters:
WIDTH, 8, number of independent input channels (1..32)
SYNC_STAGES, 2, synchroniser flop depth per channel (2..4)
COUNT_W, 16, width of the saturating edge counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
sig_in  input  WIDTH  asynchronous input lines
edge_mode  input  2  00 rising, 01 falling, 10 both, 11 disabled; applies to all channels
clear_sticky  input  WIDTH  per-channel synchronous clear of sticky bits
count_clear  input  1  synchronous clear of edge_count
pos_edge_detected  output  WIDTH  one-cycle pulse per channel on a selected edge
any_edge  output  1  OR of pos_edge_detected, same cycle
sticky  output  WIDTH  per-channel latched detection flag
edge_count  output  COUNT_W  saturating total of detected edges across all channels

Behaviour:
- Reset: asynchronous, active-high. While rst=1, all synchroniser flops, history flops, pos_edge_detected, any_edge, sticky and edge_count are 0. The arm counter is cleared.
- Synchroniser: per channel, a chain of SYNC_STAGES flops; s = last stage output. A history flop p <= s every cycle.
- Detect per channel:
  - rise = s & ~p
  - fall = ~s & p
  - mode 00 selects rise; 01 selects fall; 10 selects rise|fall; 11 selects 0.
- Latency: sig_in stable high from before edge N (setup met) -> pos_edge_detected high for exactly the cycle after edge N+SYNC_STAGES, then low. Registered output, no combinational path from inputs.
- Arming: after rst deasserts, detection is suppressed for SYNC_STAGES+1 cycles while s/p fill. An input held high through reset release produces no pulse. The arm counter saturates at SYNC_STAGES+1 and holds until next reset.
- Pulses shorter than one clock may be missed; no requirement to catch them.
- Input toggling every cycle in mode 10 produces a pulse every cycle.
- any_edge is registered in the same cycle as pos_edge_detected.
- sticky[i]:
  - Set on the cycle pos_edge_detected[i] asserts.
  - Cleared the cycle after clear_sticky[i]=1.
  - Simultaneous set and clear: set wins (event not lost).
- edge_count:
  - Each cycle adds popcount(detect vector), 0..WIDTH, computed in COUNT_W+1 bits.
  - Saturates at 2^COUNT_W-1 and never wraps.
  - count_clear=1 loads the cycle's popcount instead of 0; an event in the clear cycle is counted.
- edge_mode change: takes effect on the next cycle's detection; no pulse is generated by the mode change itself.
- Reset mid-operation: immediate clear of all state; re-arming applies again.

Decomposition:
- Shared package edge_det_pkg holds the edge_mode encoding constants: MODE_RISE=2'b00, MODE_FALL=2'b01, MODE_BOTH=2'b10, MODE_OFF=2'b11.
- One sub-module, edge_sync_cell: a single-bit synchroniser plus history flop, outputs s and p, parameter SYNC_STAGES, async active-high reset. Instantiate WIDTH times in a generate loop.
- Popcount, saturation, arming and sticky logic live in the top module.

Test Plan:
- Defaults, mode 00: rst high 3 cycles, release. Raise sig_in[0] before edge 10 -> pos_edge_detected=8'h01 only in the cycle after edge 12, any_edge=1 same cycle, sticky=8'h01, edge_count=1.
- Mode 00, falling edge: drop sig_in[0] -> no pulse, edge_count stays 1. Switch to mode 01 and repeat rise then fall -> pulse only on the fall.
- Mode 10: toggle sig_in[3] every cycle for 6 cycles -> 6 consecutive pulses on bit 3, edge_count increases by 6.
- Simultaneous edges: raise sig_in=8'hFF in one cycle -> pos_edge_detected=8'hFF for one cycle, edge_count increases by 8. Assert clear_sticky[2] in the same cycle as a bit-2 event -> sticky[2] remains 1.
- Saturation with COUNT_W=4: 20 rising edges -> edge_count stops at 15. count_clear with no event -> 0.
- Reset and arming: hold sig_in=8'hFF through reset release -> no pulse for any channel. Assert rst mid-pulse -> all outputs 0 immediately. Mode 11 -> no pulses for any stimulus.

Source files
------------

// File: rtl/edge_det_pkg.sv
// Shared definitions for the multi-channel edge detector.
// Holds the edge_mode encoding used by the interface, top and bench.
package edge_det_pkg;

    typedef logic [1:0] edge_mode_t;

    localparam edge_mode_t MODE_RISE = 2'b00;
    localparam edge_mode_t MODE_FALL = 2'b01;
    localparam edge_mode_t MODE_BOTH = 2'b10;
    localparam edge_mode_t MODE_OFF  = 2'b11;

endpackage

// File: rtl/rising_edge_detector_if.sv
// Bundle of the edge detector's data/control lines.
// master: drives sig_in, edge_mode, clear_sticky, count_clear;
// slave: drives pos_edge_detected, any_edge, sticky, edge_count.
interface rising_edge_detector_if
    import edge_det_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 16
);

    logic [WIDTH-1:0]   sig_in;
    edge_mode_t         edge_mode;
    logic [WIDTH-1:0]   clear_sticky;
    logic               count_clear;
    logic [WIDTH-1:0]   pos_edge_detected;
    logic               any_edge;
    logic [WIDTH-1:0]   sticky;
    logic [COUNT_W-1:0] edge_count;

    modport master (
        output sig_in,
        output edge_mode,
        output clear_sticky,
        output count_clear,
        input  pos_edge_detected,
        input  any_edge,
        input  sticky,
        input  edge_count
    );

    modport slave (
        input  sig_in,
        input  edge_mode,
        input  clear_sticky,
        input  count_clear,
        output pos_edge_detected,
        output any_edge,
        output sticky,
        output edge_count
    );

endinterface

// File: rtl/edge_sync_cell.sv
// Single-bit synchroniser chain followed by a history flop.
// Ports: clk, rst (async high), d (async in), s (synced), p (s delayed).
module edge_sync_cell #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic s,
    output logic p
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
            p     <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
            p     <= chain[SYNC_STAGES-1];
        end
    end

    assign s = chain[SYNC_STAGES-1];

endmodule

// File: rtl/rising_edge_detector.sv
// Multi-channel synchronising edge detector with sticky flags and counter.
// Ports: clk, rst (async high), bus (slave side of rising_edge_detector_if).
module rising_edge_detector
    import edge_det_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int COUNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    rising_edge_detector_if.slave bus
);

    localparam int ARM_W = $clog2(SYNC_STAGES + 2);
    localparam int PC_W  = $clog2(WIDTH + 1);
    localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

    logic [WIDTH-1:0]   s;
    logic [WIDTH-1:0]   p;
    logic [WIDTH-1:0]   rise;
    logic [WIDTH-1:0]   fall;
    logic [WIDTH-1:0]   det;
    logic [ARM_W-1:0]   arm_cnt;
    logic               armed;
    logic [PC_W-1:0]    pc;
    logic [COUNT_W-1:0] base;
    logic [COUNT_W:0]   sum;
    logic [COUNT_W-1:0] count_d;

    logic [WIDTH-1:0]   pos_q;
    logic               any_q;
    logic [WIDTH-1:0]   sticky_q;
    logic [COUNT_W-1:0] count_q;

    function automatic logic [PC_W-1:0] popcount(
        input logic [WIDTH-1:0] v
    );
        logic [PC_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            acc = acc + PC_W'(v[i]);
        end
        return acc;
    endfunction

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        edge_sync_cell #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_cell (
            .clk(clk),
            .rst(rst),
            .d  (bus.sig_in[i]),
            .s  (s[i]),
            .p  (p[i])
        );
    end

    // Detection stays off until the sync chain and history flop hold
    // only post-reset samples, so a line held high through reset is quiet.
    assign armed = (arm_cnt == ARM_DONE);
    assign rise  = s & ~p;
    assign fall  = ~s & p;

    always_comb begin
        det = '0;
        if (armed) begin
            unique case (bus.edge_mode)
                MODE_RISE: det = rise;
                MODE_FALL: det = fall;
                MODE_BOTH: det = rise | fall;
                MODE_OFF:  det = '0;
            endcase
        end
    end

    // One spare bit catches overflow; a clear still counts this cycle's edges.
    always_comb begin
        pc      = popcount(det);
        base    = bus.count_clear ? '0 : count_q;
        sum     = {1'b0, base} + (COUNT_W + 1)'(pc);
        count_d = sum[COUNT_W] ? '1 : sum[COUNT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arm_cnt  <= '0;
            pos_q    <= '0;
            any_q    <= 1'b0;
            sticky_q <= '0;
            count_q  <= '0;
        end else begin
            if (!armed) begin
                arm_cnt <= arm_cnt + ARM_W'(1);
            end
            pos_q    <= det;
            any_q    <= |det;
            // New events win over a same-cycle clear.
            sticky_q <= (sticky_q & ~bus.clear_sticky) | det;
            count_q  <= count_d;
        end
    end

    assign bus.pos_edge_detected = pos_q;
    assign bus.any_edge          = any_q;
    assign bus.sticky            = sticky_q;
    assign bus.edge_count        = count_q;

endmodule

// File: tb/tb_rising_edge_detector.sv
// Self-checking bench for rising_edge_detector.
// Directed vector table, hand sequences, and random run vs a sample-history model.
module tb_rising_edge_detector;
    import edge_det_pkg::*;

    localparam int W   = 8;
    localparam int S   = 2;
    localparam int CW  = 16;
    localparam int CWS = 4;
    localparam int MAXA = (1 << CW) - 1;
    localparam int MAXB = (1 << CWS) - 1;
    localparam int NV  = 43;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] sig_in;
    logic [1:0]   edge_mode;
    logic [W-1:0] clear_sticky;
    logic         count_clear;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rising_edge_detector_if #(.WIDTH(W), .COUNT_W(CW))  bus_a ();
    rising_edge_detector_if #(.WIDTH(W), .COUNT_W(CWS)) bus_b ();

    assign bus_a.sig_in       = sig_in;
    assign bus_a.edge_mode    = edge_mode;
    assign bus_a.clear_sticky = clear_sticky;
    assign bus_a.count_clear  = count_clear;
    assign bus_b.sig_in       = sig_in;
    assign bus_b.edge_mode    = edge_mode;
    assign bus_b.clear_sticky = clear_sticky;
    assign bus_b.count_clear  = count_clear;

    rising_edge_detector #(
        .WIDTH(W), .SYNC_STAGES(S), .COUNT_W(CW)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave)
    );

    rising_edge_detector #(
        .WIDTH(W), .SYNC_STAGES(S), .COUNT_W(CWS)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave)
    );

    // Reference model: keep the sampled input history since reset.
    // Output after edge n compares samples n-S and n-S-1, both of
    // which must have been taken after reset release.
    logic [W-1:0] hq[$];
    int           m_n;
    logic [W-1:0] m_pos;
    logic [W-1:0] m_sticky;
    int           m_cnt;
    int           m_cntb;
    logic [W-1:0] m_new;
    logic [W-1:0] m_old;
    logic [W-1:0] m_det;
    int           m_pc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hq.delete();
            m_n      = 0;
            m_pos    = '0;
            m_sticky = '0;
            m_cnt    = 0;
            m_cntb   = 0;
        end else begin
            hq.push_front(sig_in);
            if (hq.size() > S + 2) void'(hq.pop_back());
            m_n++;
            m_det = '0;
            if (m_n >= S + 2) begin
                m_new = hq[S];
                m_old = hq[S+1];
                case (edge_mode)
                    MODE_RISE: m_det = m_new & ~m_old;
                    MODE_FALL: m_det = ~m_new & m_old;
                    MODE_BOTH: m_det = m_new ^ m_old;
                    default:   m_det = '0;
                endcase
            end
            m_pc     = $countones(m_det);
            m_pos    = m_det;
            m_sticky = (m_sticky & ~clear_sticky) | m_det;
            if (count_clear) begin
                m_cnt  = m_pc;
                m_cntb = m_pc;
            end else begin
                m_cnt  = (m_cnt + m_pc > MAXA) ? MAXA : m_cnt + m_pc;
                m_cntb = (m_cntb + m_pc > MAXB) ? MAXB : m_cntb + m_pc;
            end
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("model_pos", 32'(bus_a.pos_edge_detected), 32'(m_pos));
        chk("model_any", 32'(bus_a.any_edge), 32'(|m_pos));
        chk("model_sticky", 32'(bus_a.sticky), 32'(m_sticky));
        chk("model_count", 32'(bus_a.edge_count), 32'(m_cnt));
        chk("model_count4", 32'(bus_b.edge_count), 32'(m_cntb));
    endtask

    task automatic check_zero(string nm);
        chk({nm, "_pos"}, 32'(bus_a.pos_edge_detected), 32'h0);
        chk({nm, "_any"}, 32'(bus_a.any_edge), 32'h0);
        chk({nm, "_sticky"}, 32'(bus_a.sticky), 32'h0);
        chk({nm, "_count"}, 32'(bus_a.edge_count), 32'h0);
        chk({nm, "_count4"}, 32'(bus_b.edge_count), 32'h0);
    endtask

    typedef struct {
        logic [W-1:0] sig;
        logic [1:0]   mode;
        logic [W-1:0] clr;
        logic         cclr;
        logic [W-1:0] pos;
        logic [W-1:0] stk;
        int           cnt;
        int           cntb;
    } vec_t;

    vec_t tv[NV+1];

    task automatic put(int lo, int hi, logic [W-1:0] sig, logic [1:0] mode,
                       logic [W-1:0] clr, logic cclr, logic [W-1:0] pos,
                       logic [W-1:0] stk, int cnt, int cntb);
        for (int k = lo; k <= hi; k++) begin
            tv[k] = '{sig, mode, clr, cclr, pos, stk, cnt, cntb};
        end
    endtask

    initial begin
        bit seen;

        // Index k = k-th clock edge after reset release.
        put( 1,  9, 8'h00, 2'd0, 8'h00, 0, 8'h00, 8'h00,  0,  0);
        put(10, 11, 8'h01, 2'd0, 8'h00, 0, 8'h00, 8'h00,  0,  0);
        put(12, 12, 8'h01, 2'd0, 8'h00, 0, 8'h01, 8'h01,  1,  1);
        put(13, 15, 8'h00, 2'd0, 8'h00, 0, 8'h00, 8'h01,  1,  1);
        put(16, 16, 8'h00, 2'd1, 8'h00, 0, 8'h00, 8'h01,  1,  1);
        put(17, 19, 8'h01, 2'd1, 8'h00, 0, 8'h00, 8'h01,  1,  1);
        put(20, 21, 8'h00, 2'd1, 8'h00, 0, 8'h00, 8'h01,  1,  1);
        put(22, 22, 8'h00, 2'd1, 8'h00, 0, 8'h01, 8'h01,  2,  2);
        put(23, 23, 8'h08, 2'd2, 8'h00, 0, 8'h00, 8'h01,  2,  2);
        put(24, 24, 8'h00, 2'd2, 8'h00, 0, 8'h00, 8'h01,  2,  2);
        put(25, 25, 8'h08, 2'd2, 8'h00, 0, 8'h08, 8'h09,  3,  3);
        put(26, 26, 8'h00, 2'd2, 8'h00, 0, 8'h08, 8'h09,  4,  4);
        put(27, 27, 8'h08, 2'd2, 8'h00, 0, 8'h08, 8'h09,  5,  5);
        put(28, 28, 8'h00, 2'd2, 8'h00, 0, 8'h08, 8'h09,  6,  6);
        put(29, 29, 8'h00, 2'd2, 8'h00, 0, 8'h08, 8'h09,  7,  7);
        put(30, 30, 8'h00, 2'd2, 8'h00, 0, 8'h08, 8'h09,  8,  8);
        put(31, 32, 8'hFF, 2'd2, 8'h00, 0, 8'h00, 8'h09,  8,  8);
        put(33, 33, 8'hFF, 2'd2, 8'h04, 0, 8'hFF, 8'hFF, 16, 15);
        put(34, 34, 8'hFF, 2'd2, 8'hFF, 0, 8'h00, 8'h00, 16, 15);
        put(35, 35, 8'hFF, 2'd2, 8'h00, 0, 8'h00, 8'h00, 16, 15);
        put(36, 36, 8'hFF, 2'd2, 8'h00, 1, 8'h00, 8'h00,  0,  0);
        put(37, 38, 8'h00, 2'd2, 8'h00, 0, 8'h00, 8'h00,  0,  0);
        put(39, 39, 8'h00, 2'd2, 8'h00, 1, 8'hFF, 8'hFF,  8,  8);
        put(40, 40, 8'h0F, 2'd3, 8'h00, 0, 8'h00, 8'hFF,  8,  8);
        put(41, 41, 8'hF0, 2'd3, 8'h00, 0, 8'h00, 8'hFF,  8,  8);
        put(42, 42, 8'h0F, 2'd3, 8'h00, 0, 8'h00, 8'hFF,  8,  8);
        put(43, 43, 8'h00, 2'd3, 8'h00, 0, 8'h00, 8'hFF,  8,  8);

        rst          = 1'b1;
        sig_in       = '0;
        edge_mode    = MODE_RISE;
        clear_sticky = '0;
        count_clear  = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        for (int k = 1; k <= NV; k++) begin
            sig_in       = tv[k].sig;
            edge_mode    = tv[k].mode;
            clear_sticky = tv[k].clr;
            count_clear  = tv[k].cclr;
            @(negedge clk);
            chk($sformatf("vec%0d_pos", k), 32'(bus_a.pos_edge_detected), 32'(tv[k].pos));
            chk($sformatf("vec%0d_any", k), 32'(bus_a.any_edge), 32'(|tv[k].pos));
            chk($sformatf("vec%0d_sticky", k), 32'(bus_a.sticky), 32'(tv[k].stk));
            chk($sformatf("vec%0d_count", k), 32'(bus_a.edge_count), 32'(tv[k].cnt));
            chk($sformatf("vec%0d_count4", k), 32'(bus_b.edge_count), 32'(tv[k].cntb));
            check_model();
        end

        // Line held high through reset release must not pulse.
        rst          = 1'b1;
        sig_in       = 8'hFF;
        edge_mode    = MODE_RISE;
        clear_sticky = '0;
        count_clear  = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("hold_rst");
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("hold_release_pos", 32'(bus_a.pos_edge_detected), 32'h0);
            check_model();
        end

        // Reset asserted while a pulse is visible clears everything at once.
        sig_in = 8'h00;
        repeat (4) begin
            @(negedge clk);
            check_model();
        end
        sig_in = 8'hFF;
        seen   = 1'b0;
        for (int k = 0; k < 6 && !seen; k++) begin
            @(negedge clk);
            check_model();
            if (bus_a.pos_edge_detected != 0) seen = 1'b1;
        end
        chk("midpulse_seen", 32'(seen), 32'h1);
        chk("midpulse_pos", 32'(bus_a.pos_edge_detected), 32'hFF);
        rst = 1'b1;
        #1;
        check_zero("midpulse_rst");
        @(negedge clk);
        rst = 1'b0;

        // Random traffic against the model.
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 3) == 0)
                sig_in = W'($urandom);
            else
                sig_in = sig_in ^ W'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 15) == 0) edge_mode = 2'($urandom_range(0, 3));
            clear_sticky = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
            count_clear  = ($urandom_range(0, 31) == 0);
            rst          = ($urandom_range(0, 199) == 0);
            @(negedge clk);
            if (rst) begin
                check_zero("rand_rst");
                rst = 1'b0;
            end else begin
                check_model();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
